// File: rtl/dac_sched_pkg.sv
// Shared types and reset defaults for the DAC sample scheduler.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_HOST    = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_AUTO    = 2'd3
    } mode_t;

    typedef enum logic {
        SHAPE_SAW = 1'b0,
        SHAPE_TRI = 1'b1
    } shape_t;

    localparam logic [1:0] CFG_SEL_DIV   = 2'd0;
    localparam logic [1:0] CFG_SEL_MODE  = 2'd1;
    localparam logic [1:0] CFG_SEL_STEP  = 2'd2;
    localparam logic [1:0] CFG_SEL_SHAPE = 2'd3;

    localparam logic [7:0] PKG_DEFAULT_DIV  = 8'd9;
    localparam logic [7:0] PKG_RESET_CODE   = 8'h80;
    localparam logic [7:0] PKG_DEFAULT_STEP = 8'd1;

    // Sawtooth advance: plain modulo-256 add, so 255 + step wraps through zero.
    function automatic logic [7:0] saw_next(input logic [7:0] code, input logic [7:0] step);
        return code + step;
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous host-sample FIFO, DEPTH x WIDTH, no bypass (a push is poppable the next cycle).
module dac_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Per-tick source selection for the R2R DAC code register (host FIFO or ramp generator).
// Optional triangle shape is enabled by defining DAC_SCHED_TRIANGLE_EN.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] DEFAULT_DIV = PKG_DEFAULT_DIV,
    parameter logic [7:0] RESET_CODE  = PKG_RESET_CODE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [1:0]                    cfg_sel,
    input  logic [7:0]                    cfg_data,
    input  logic                          host_valid,
    input  logic [7:0]                    host_data,
    output logic                          host_ready,
    output logic [7:0]                    dac_code,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic [7:0] div_q;
    logic [7:0] cnt_q;
    logic [7:0] step_q;
    mode_t      mode_q;

    logic       cfg_div_wr;
    logic       cfg_mode_wr;
    logic       cfg_step_wr;
    logic       tick;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    logic [7:0] gen_code;
    logic [7:0] next_code;
    logic       use_gen;
    logic       underrun_set;

    assign cfg_div_wr  = cfg_load && (cfg_sel == CFG_SEL_DIV);
    assign cfg_mode_wr = cfg_load && (cfg_sel == CFG_SEL_MODE);
    assign cfg_step_wr = cfg_load && (cfg_sel == CFG_SEL_STEP);

    // A divider write restarts the count, so the old terminal count must not fire alongside it.
    assign tick = (cnt_q == div_q) && !cfg_div_wr;

    assign host_ready = !fifo_full;
    assign fifo_push  = host_valid && host_ready;

    dac_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (host_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef DAC_SCHED_TRIANGLE_EN
    shape_t     shape_q;
    logic       dir_up_q;
    logic       gen_dir_up;
    logic       cfg_shape_wr;
    logic [8:0] up_sum;

    assign cfg_shape_wr = cfg_load && (cfg_sel == CFG_SEL_SHAPE);
    assign up_sum       = {1'b0, dac_code} + {1'b0, step_q};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gen_code   = saw_next(dac_code, step_q);
        gen_dir_up = dir_up_q;
        if (shape_q == SHAPE_TRI) begin
            if (dir_up_q) begin
                if (up_sum[8]) begin
                    gen_code   = 8'hFF;
                    gen_dir_up = 1'b0;
                end else begin
                    gen_code = up_sum[7:0];
                end
            end else begin
                if (dac_code < step_q) begin
                    gen_code   = 8'h00;
                    gen_dir_up = 1'b1;
                end else begin
                    gen_code = dac_code - step_q;
                end
            end
        end
    end

    // Direction only advances when the generator actually drives the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            shape_q  <= SHAPE_SAW;
            dir_up_q <= 1'b1;
        end else if (cfg_shape_wr) begin
            shape_q  <= shape_t'(cfg_data[0]);
            dir_up_q <= 1'b1;
        end else if (use_gen) begin
            dir_up_q <= gen_dir_up;
        end
    end
`else
    assign gen_code = saw_next(dac_code, step_q);
`endif

    // The generator always advances from the live dac_code, so switching sources never jumps.
    always_comb begin
        next_code    = dac_code;
        fifo_pop     = 1'b0;
        use_gen      = 1'b0;
        underrun_set = 1'b0;
        if (tick) begin
            case (mode_q)
                MODE_HOLD: begin
                    next_code = dac_code;
                end
                MODE_HOST: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        next_code = fifo_dout;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
                MODE_PATTERN: begin
                    use_gen   = 1'b1;
                    next_code = gen_code;
                end
                MODE_AUTO: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        next_code = fifo_dout;
                    end else begin
                        use_gen   = 1'b1;
                        next_code = gen_code;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DEFAULT_DIV;
            cnt_q  <= 8'd0;
            mode_q <= MODE_HOLD;
            step_q <= PKG_DEFAULT_STEP;
        end else begin
            if (cfg_div_wr) begin
                div_q <= cfg_data;
                cnt_q <= 8'd0;
            end else if (tick) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (cfg_mode_wr) mode_q <= mode_t'(cfg_data[1:0]);
            if (cfg_step_wr) step_q <= cfg_data;
        end
    end

    // A same-cycle underrun event outranks the clear from a mode write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code    <= RESET_CODE;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            dac_code    <= next_code;
            sample_tick <= tick;
            if (underrun_set)     underrun <= 1'b1;
            else if (cfg_mode_wr) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed self-checking bench for dac_sample_scheduler; outputs sampled on the falling edge.
module tb_dac_sample_scheduler;

    localparam logic [1:0] SEL_DIV   = 2'd0;
    localparam logic [1:0] SEL_MODE  = 2'd1;
    localparam logic [1:0] SEL_STEP  = 2'd2;
    localparam logic [1:0] SEL_SHAPE = 2'd3;

    localparam logic [7:0] M_HOLD    = 8'd0;
    localparam logic [7:0] M_HOST    = 8'd1;
    localparam logic [7:0] M_PATTERN = 8'd2;
    localparam logic [7:0] M_AUTO    = 8'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_ready;
    logic [7:0] dac_code;
    logic       sample_tick;
    logic       underrun;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_pat  [5] = '{8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0};
    logic [7:0] host_vec [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef DAC_SCHED_TRIANGLE_EN
    logic [7:0] exp_shape [6] = '{8'hE0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};
`else
    logic [7:0] exp_shape [6] = '{8'hE0, 8'h40, 8'hA0, 8'h00, 8'h60, 8'hC0};
`endif

    always #5 clk = ~clk;

    dac_sample_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .dac_code    (dac_code),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    task automatic check8(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
        cfg_load = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check8(tag, dac_code, 8'h80);
        check_bit(tag, sample_tick, 1'b0);
        check_bit(tag, underrun, 1'b0);
        check_bit(tag, host_ready, 1'b1);
        check8(tag, 8'(fifo_level), 8'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_load   = 1'b0;
        cfg_sel    = 2'd0;
        cfg_data   = 8'd0;
        host_valid = 1'b0;
        host_data  = 8'd0;
        step_n(2);
        check_reset_state("reset");
        rst = 1'b0;

        // HOLD: code frozen, tick every 10 clocks with the default divider
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            check_bit("hold_tick", sample_tick, (i % 10) == 0);
            check8("hold_code", dac_code, 8'h80);
        end
        check_bit("hold_underrun", underrun, 1'b0);

        // PATTERN, step 0x40, tick every cycle, wrap through zero
        cfg_write(SEL_DIV, 8'd0);
        check_bit("div0_write_no_tick", sample_tick, 1'b0);
        cfg_write(SEL_STEP, 8'h40);
        cfg_write(SEL_MODE, M_PATTERN);
        check8("pattern_start", dac_code, 8'h80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check8("pattern_code", dac_code, exp_pat[i]);
            check_bit("pattern_tick", sample_tick, 1'b1);
        end

        // HOST: fill FIFO without ticks, fifth push refused
        cfg_write(SEL_DIV, 8'd200);
        check8("div_write_holds_code", dac_code, 8'hC0);
        cfg_write(SEL_MODE, M_HOST);
        for (int i = 0; i < 4; i++) begin
            check_bit("host_ready_before_push", host_ready, 1'b1);
            host_valid = 1'b1;
            host_data  = host_vec[i];
            @(negedge clk);
        end
        check_bit("host_ready_full", host_ready, 1'b0);
        check8("level_full", 8'(fifo_level), 8'd4);
        host_data = 8'hE5;
        @(negedge clk);
        host_valid = 1'b0;
        check8("level_after_refused_push", 8'(fifo_level), 8'd4);
        cfg_write(SEL_DIV, 8'd0);
        check8("host_no_tick_yet", dac_code, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check8("host_code", dac_code, host_vec[i]);
            check_bit("host_tick", sample_tick, 1'b1);
            check_bit("host_no_underrun", underrun, 1'b0);
        end
        check8("level_drained", 8'(fifo_level), 8'd0);
        check_bit("host_ready_drained", host_ready, 1'b1);
        @(negedge clk);
        check8("underrun_hold_code", dac_code, 8'hD4);
        check_bit("underrun_tick", sample_tick, 1'b1);
        check_bit("underrun_set", underrun, 1'b1);
        cfg_write(SEL_DIV, 8'd200);
        check_bit("underrun_sticky", underrun, 1'b1);
        cfg_write(SEL_MODE, M_AUTO);
        check_bit("underrun_cleared", underrun, 1'b0);

        // AUTO, div=3: ramp while empty, host sample takes over, ramp resumes from it
        cfg_write(SEL_STEP, 8'h10);
        cfg_write(SEL_DIV, 8'd3);
        step_n(3);
        check_bit("auto_no_tick", sample_tick, 1'b0);
        @(negedge clk);
        check_bit("auto_tick", sample_tick, 1'b1);
        check8("auto_ramp1", dac_code, 8'hE4);
        step_n(4);
        check8("auto_ramp2", dac_code, 8'hF4);
        host_valid = 1'b1;
        host_data  = 8'h11;
        @(negedge clk);
        host_valid = 1'b0;
        check8("auto_level1", 8'(fifo_level), 8'd1);
        step_n(2);
        check8("auto_before_host", dac_code, 8'hF4);
        @(negedge clk);
        check8("auto_host", dac_code, 8'h11);
        check8("auto_level0", 8'(fifo_level), 8'd0);
        step_n(4);
        check8("auto_resume", dac_code, 8'h21);
        check_bit("auto_no_underrun", underrun, 1'b0);

        // Divider write mid-count: cnt=5, div 9->2, next tick 3 clocks later
        cfg_write(SEL_MODE, M_HOLD);
        cfg_write(SEL_DIV, 8'd9);
        step_n(5);
        cfg_write(SEL_DIV, 8'd2);
        check_bit("midcount_no_tick", sample_tick, 1'b0);
        @(negedge clk);
        check_bit("midcount_plus1", sample_tick, 1'b0);
        @(negedge clk);
        check_bit("midcount_plus2", sample_tick, 1'b0);
        @(negedge clk);
        check_bit("midcount_plus3", sample_tick, 1'b1);
        step_n(2);
        cfg_write(SEL_DIV, 8'd2);
        check_bit("terminal_write_suppressed", sample_tick, 1'b0);
        step_n(2);
        @(negedge clk);
        check_bit("tick_after_suppress", sample_tick, 1'b1);

        // Underrun set beats mode-write clear in the same cycle
        cfg_write(SEL_DIV, 8'd0);
        cfg_write(SEL_MODE, M_HOST);
        check_bit("host_enter_no_underrun", underrun, 1'b0);
        @(negedge clk);
        check_bit("host_empty_underrun", underrun, 1'b1);
        cfg_write(SEL_MODE, M_HOST);
        check_bit("set_beats_clear", underrun, 1'b1);

        // Reset mid-stream with FIFO holding data
        host_valid = 1'b1;
        host_data  = 8'h5A;
        @(negedge clk);
        host_data  = 8'h6B;
        @(negedge clk);
        host_valid = 1'b0;
        check8("midstream_code", dac_code, 8'h5A);
        check8("midstream_level", 8'(fifo_level), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midstream_reset");
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_bit("post_reset_tick", sample_tick, i == 10);
            check8("post_reset_code", dac_code, 8'h80);
        end

        // Default step after reset is 1
        cfg_write(SEL_DIV, 8'd0);
        cfg_write(SEL_MODE, M_PATTERN);
        @(negedge clk);
        check8("default_step", dac_code, 8'h81);

        // Shape select: triangle when enabled, otherwise ignored (saw)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg_write(SEL_SHAPE, 8'd1);
        cfg_write(SEL_STEP, 8'h60);
        cfg_write(SEL_DIV, 8'd0);
        cfg_write(SEL_MODE, M_PATTERN);
        check8("shape_start", dac_code, 8'h80);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check8("shape_code", dac_code, exp_shape[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
